// File: rtl/spi_frame_pkg.sv
// Shared types and CRC-8 helper for the SPI frame receive (and future transmit) paths.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_CRC   = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    COMMIT
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/spi_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, MSB first, no reflection, no final XOR).
module spi_crc8_serial
  import spi_frame_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit_in,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_crc <= CRC8_INIT;
    end else if (i_en) begin
      r_crc <= crc8_step(r_crc, i_bit_in);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: oversampled capture, length/CRC validation and atomic commit
// of the payload, plus a stretched system-time-update flag.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 51,
  parameter bit          CRC_EN        = 1'b1,
  parameter int unsigned TIME_BYTES    = 8,
  parameter int unsigned HOLD_CYCLES   = 128
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clk_en,
  input  logic                       i_sclk,
  input  logic                       i_cs_n,
  input  logic                       i_mosi,
  output logic [PAYLOAD_BYTES*8-1:0] o_frame_data,
  output logic                       o_frame_wr,
  output logic                       o_frame_err,
  output logic [1:0]                 o_err_code,
  output logic                       o_sys_time_update,
  output logic [15:0]                o_frame_cnt
);

  localparam int unsigned PayloadBits = PAYLOAD_BYTES * 8;
  localparam int unsigned NBits       = (PAYLOAD_BYTES + (CRC_EN ? 1 : 0)) * 8;
  localparam int unsigned CntW        = $clog2(NBits + 1);
  localparam int unsigned TimeBits    = TIME_BYTES * 8;

  localparam logic [CntW-1:0] CntFull    = CntW'(NBits);
  localparam logic [CntW-1:0] CntOvf     = CntW'(NBits + 1);
  localparam logic [CntW-1:0] CntPayload = CntW'(PayloadBits);
  localparam logic [7:0]      HoldLoad   = 8'(HOLD_CYCLES - 1);

  // Synchronisers run every clk; the extra delay stage feeds the edge detectors.
  logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
  logic r_cs_meta, r_cs_sync, r_cs_dly;
  logic r_mosi_meta, r_mosi_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_dly  <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_cs_dly    <= 1'b1;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_dly  <= r_sclk_sync;
      r_cs_meta   <= i_cs_n;
      r_cs_sync   <= r_cs_meta;
      r_cs_dly    <= r_cs_sync;
      r_mosi_meta <= i_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  logic w_sclk_rise, w_cs_rise, w_cs_fall;
  assign w_sclk_rise = r_sclk_sync & ~r_sclk_dly;
  assign w_cs_rise   = r_cs_sync & ~r_cs_dly;
  assign w_cs_fall   = ~r_cs_sync & r_cs_dly;

  state_e           r_state, w_state_next;
  logic [CntW-1:0]  r_cnt, w_cnt_next;
  logic [NBits-1:0] r_shift, w_shift_next;
  logic [7:0]       w_crc;
  logic             w_crc_clr, w_crc_en, w_err_pulse, w_commit;
  err_e             w_err_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_crc_clr    = 1'b0;
    w_crc_en     = 1'b0;
    w_err_pulse  = 1'b0;
    w_err_next   = ERR_NONE;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next = RECV;
          w_cnt_next   = '0;
          w_crc_clr    = 1'b1;
        end
      end
      RECV: begin
        if (w_sclk_rise) begin
          if (r_cnt < CntFull) begin
            w_shift_next = {r_shift[NBits-2:0], r_mosi_sync};
            w_cnt_next   = r_cnt + 1'b1;
            w_crc_en     = (r_cnt < CntPayload);
          end else begin
            w_cnt_next = CntOvf;
          end
        end
        if (w_cs_rise) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        w_state_next = IDLE;
        // A zero count is a CS glitch: drop it silently.
        if (r_cnt != '0) begin
          if (r_cnt < CntFull) begin
            w_err_pulse = 1'b1;
            w_err_next  = ERR_SHORT;
          end else if (r_cnt > CntFull) begin
            w_err_pulse = 1'b1;
            w_err_next  = ERR_LONG;
          end else if (CRC_EN && (r_shift[7:0] != w_crc)) begin
            w_err_pulse = 1'b1;
            w_err_next  = ERR_CRC;
          end else begin
            w_state_next = COMMIT;
            w_commit     = 1'b1;
          end
        end
      end
      COMMIT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  spi_crc8_serial u_crc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_crc_clr & i_clk_en),
    .i_en     (w_crc_en & i_clk_en),
    .i_bit_in (r_mosi_sync),
    .o_crc    (w_crc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_clk_en) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
    end
  end

  logic [PayloadBits-1:0] r_frame_data;
  logic                   r_frame_wr, r_frame_err, r_sys;
  err_e                   r_err_code;
  logic [15:0]            r_frame_cnt;
  logic [7:0]             r_timer;
  logic                   w_time_nz;

  assign w_time_nz = |r_shift[NBits-1 -: TimeBits];

  // Results are registered on the CHECK decision so data and strobe appear together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_frame_data <= '0;
      r_frame_wr   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_frame_cnt  <= '0;
      r_timer      <= '0;
      r_sys        <= 1'b0;
    end else begin
      r_frame_wr  <= 1'b0;
      r_frame_err <= 1'b0;
      if (i_clk_en) begin
        if (w_err_pulse) begin
          r_frame_err <= 1'b1;
          r_err_code  <= w_err_next;
        end
        if (w_commit) begin
          r_frame_data <= r_shift[NBits-1 -: PayloadBits];
          r_frame_wr   <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
        end
        if (w_commit && w_time_nz) begin
          r_timer <= HoldLoad;
          r_sys   <= 1'b1;
        end else if (r_timer != 8'd0) begin
          r_timer <= r_timer - 8'd1;
        end else begin
          r_sys <= 1'b0;
        end
      end
    end
  end

  assign o_frame_data      = r_frame_data;
  assign o_frame_wr        = r_frame_wr;
  assign o_frame_err       = r_frame_err;
  assign o_err_code        = r_err_code;
  assign o_sys_time_update = r_sys;
  assign o_frame_cnt       = r_frame_cnt;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a 1-byte CRC config, the default config and a no-CRC config.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [2:0] cs_n = 3'b111;

  always #5 clk = ~clk;

  logic [7:0]   s_data;
  logic [407:0] b_data, n_data;
  logic         s_wr, s_err, s_sys, b_wr, b_err, b_sys, n_wr, n_err, n_sys;
  logic [1:0]   s_code, b_code, n_code;
  logic [15:0]  s_cnt, b_cnt, n_cnt;

  spi_frame_rx #(.PAYLOAD_BYTES(1), .CRC_EN(1'b1), .TIME_BYTES(1), .HOLD_CYCLES(128)) u_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_sclk(sclk), .i_cs_n(cs_n[0]),
    .i_mosi(mosi), .o_frame_data(s_data), .o_frame_wr(s_wr), .o_frame_err(s_err),
    .o_err_code(s_code), .o_sys_time_update(s_sys), .o_frame_cnt(s_cnt)
  );

  spi_frame_rx u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_sclk(sclk), .i_cs_n(cs_n[1]),
    .i_mosi(mosi), .o_frame_data(b_data), .o_frame_wr(b_wr), .o_frame_err(b_err),
    .o_err_code(b_code), .o_sys_time_update(b_sys), .o_frame_cnt(b_cnt)
  );

  spi_frame_rx #(.CRC_EN(1'b0)) u_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_sclk(sclk), .i_cs_n(cs_n[2]),
    .i_mosi(mosi), .o_frame_data(n_data), .o_frame_wr(n_wr), .o_frame_err(n_err),
    .o_err_code(n_code), .o_sys_time_update(n_sys), .o_frame_cnt(n_cnt)
  );

  // Output monitor, sampled on the falling edge.
  wire [2:0] m_wr  = {n_wr, b_wr, s_wr};
  wire [2:0] m_err = {n_err, b_err, s_err};
  wire [2:0] m_sys = {n_sys, b_sys, s_sys};
  int        cyc = 0;
  int        wr_n[3] = '{0, 0, 0};
  int        err_n[3] = '{0, 0, 0};
  int        both_n[3] = '{0, 0, 0};
  int        sys_hi[3] = '{0, 0, 0};
  int        t_wr[3] = '{0, 0, 0};
  int        t_wr_prev[3] = '{0, 0, 0};
  int        t_fall[3] = '{0, 0, 0};
  logic [2:0] sys_prev = 3'b000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (m_wr[i]) begin
        wr_n[i]      <= wr_n[i] + 1;
        t_wr_prev[i] <= t_wr[i];
        t_wr[i]      <= cyc;
      end
      if (m_err[i]) err_n[i] <= err_n[i] + 1;
      if (m_wr[i] && m_err[i]) both_n[i] <= both_n[i] + 1;
      if (m_sys[i]) sys_hi[i] <= sys_hi[i] + 1;
      if (!m_sys[i] && sys_prev[i]) t_fall[i] <= cyc;
    end
    sys_prev <= m_sys;
  end

  int pass_n = 0;
  int total_n = 0;
  logic [511:0] tx;

  function automatic logic [7:0] ref_crc(input logic [511:0] v, input int nbytes);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < nbytes * 8; i++) begin
      fb = c[7] ^ v[511-i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sclk = 1'b0;
      mosi = tx[511-i];
      clks(2);
      sclk = 1'b1;
      clks(2);
    end
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input int sel, input int n);
    cs_n[sel] = 1'b0;
    clks(4);
    spi_bits(0, n);
    clks(2);
    cs_n[sel] = 1'b1;
    clks(12);
  endtask

  task automatic small_frame(input logic [7:0] b0, input logic [7:0] b1);
    tx = '0;
    tx[511 -: 8] = b0;
    tx[503 -: 8] = b1;
    spi_frame(0, 16);
  endtask

  task automatic test_reset;
    total_n++;
    if ({s_data, s_wr, s_err, s_sys, s_code, s_cnt} !== '0)
      $display("FAIL reset_small: got %h want 0", {s_data, s_wr, s_err, s_sys, s_code, s_cnt});
    else pass_n++;
    total_n++;
    if ({b_data, b_wr, b_err, b_sys, b_code, b_cnt} !== '0)
      $display("FAIL reset_big: got %h want 0", {b_wr, b_err, b_sys, b_code, b_cnt});
    else pass_n++;
    total_n++;
    if ({n_data, n_wr, n_err, n_sys, n_code, n_cnt} !== '0)
      $display("FAIL reset_nocrc: got %h want 0", {n_wr, n_err, n_sys, n_code, n_cnt});
    else pass_n++;
  endtask

  task automatic test_crc_bad;
    int w0, e0;
    w0 = wr_n[0]; e0 = err_n[0];
    small_frame(8'h01, 8'h08);
    total_n++;
    if (err_n[0] - e0 !== 1) $display("FAIL crc_bad_err_pulses: got %0d want 1", err_n[0] - e0);
    else pass_n++;
    total_n++;
    if (s_code !== 2'd3) $display("FAIL crc_bad_code: got %0d want 3", s_code);
    else pass_n++;
    total_n++;
    if ({wr_n[0] - w0, s_data, s_cnt} !== {32'd0, 8'h00, 16'h0000})
      $display("FAIL crc_bad_no_commit: got wr=%0d data=%h cnt=%0d want 0 00 0",
               wr_n[0] - w0, s_data, s_cnt);
    else pass_n++;
  endtask

  task automatic test_crc_good;
    int w0, e0, h0;
    w0 = wr_n[0]; e0 = err_n[0]; h0 = sys_hi[0];
    small_frame(8'h01, 8'h07);
    total_n++;
    if ({wr_n[0] - w0, err_n[0] - e0} !== {32'd1, 32'd0})
      $display("FAIL crc_good_pulses: got wr=%0d err=%0d want 1 0", wr_n[0] - w0, err_n[0] - e0);
    else pass_n++;
    total_n++;
    if ({s_data, s_cnt} !== {8'h01, 16'd1})
      $display("FAIL crc_good_data_cnt: got %h/%0d want 01/1", s_data, s_cnt);
    else pass_n++;
    clks(200);
    total_n++;
    if (sys_hi[0] - h0 !== 128) $display("FAIL crc_good_hold: got %0d want 128", sys_hi[0] - h0);
    else pass_n++;
  endtask

  task automatic test_glitch;
    int w0, e0;
    w0 = wr_n[0]; e0 = err_n[0];
    cs_n[0] = 1'b0;
    clks(6);
    cs_n[0] = 1'b1;
    clks(12);
    total_n++;
    if ({wr_n[0] - w0, err_n[0] - e0, s_code} !== {32'd0, 32'd0, 2'd3})
      $display("FAIL glitch: got wr=%0d err=%0d code=%0d want 0 0 3",
               wr_n[0] - w0, err_n[0] - e0, s_code);
    else pass_n++;
  endtask

  task automatic test_hold_reload;
    int h0, f1;
    h0 = sys_hi[0];
    small_frame(8'h01, 8'h07);
    small_frame(8'h00, 8'h00);
    clks(200);
    f1 = t_fall[0] - t_wr_prev[0];
    total_n++;
    if (f1 !== 128) $display("FAIL zero_time_no_shorten: got %0d want 128", f1);
    else pass_n++;
    h0 = sys_hi[0];
    small_frame(8'h01, 8'h07);
    clks(18);
    small_frame(8'h01, 8'h07);
    clks(200);
    total_n++;
    if (t_wr[0] - t_wr_prev[0] >= 128)
      $display("FAIL reload_gap: got %0d want below 128", t_wr[0] - t_wr_prev[0]);
    else pass_n++;
    total_n++;
    if (t_fall[0] - t_wr[0] !== 128)
      $display("FAIL reload_fall: got %0d want 128", t_fall[0] - t_wr[0]);
    else pass_n++;
    total_n++;
    if (sys_hi[0] - h0 !== t_fall[0] - t_wr_prev[0])
      $display("FAIL reload_continuous: got %0d want %0d", sys_hi[0] - h0,
               t_fall[0] - t_wr_prev[0]);
    else pass_n++;
    total_n++;
    if (s_cnt !== 16'd5) $display("FAIL hold_cnt: got %0d want 5", s_cnt);
    else pass_n++;
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force u_s.r_frame_cnt = 16'hFFFF;
    clks(2);
    @(negedge clk);
    release u_s.r_frame_cnt;
    clks(2);
    total_n++;
    if (s_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h want ffff", s_cnt);
    else pass_n++;
    small_frame(8'h01, 8'h07);
    total_n++;
    if (s_cnt !== 16'h0000) $display("FAIL wrap: got %h want 0000", s_cnt);
    else pass_n++;
  endtask

  task automatic build_big(input logic [7:0] tlast, input logic [7:0] fill, input bit add_crc);
    tx = '0;
    for (int i = 0; i < 51; i++) tx[511-8*i -: 8] = (i < 8) ? 8'h00 : fill;
    tx[511-8*7 -: 8] = tlast;
    if (add_crc) tx[511-8*51 -: 8] = ref_crc(tx, 51);
  endtask

  task automatic test_length_errors;
    int w0, e0;
    w0 = wr_n[1]; e0 = err_n[1];
    build_big(8'h3C, 8'h5A, 1'b1);
    spi_frame(1, 407);
    total_n++;
    if ({err_n[1] - e0, b_code} !== {32'd1, 2'd1})
      $display("FAIL short: got err=%0d code=%0d want 1 1", err_n[1] - e0, b_code);
    else pass_n++;
    spi_frame(1, 417);
    total_n++;
    if ({err_n[1] - e0, b_code} !== {32'd2, 2'd2})
      $display("FAIL long: got err=%0d code=%0d want 2 2", err_n[1] - e0, b_code);
    else pass_n++;
    total_n++;
    if ({wr_n[1] - w0, b_cnt} !== {32'd0, 16'd0} || b_data !== '0)
      $display("FAIL length_no_commit: got wr=%0d cnt=%0d want 0 0", wr_n[1] - w0, b_cnt);
    else pass_n++;
  endtask

  task automatic test_nocrc;
    int w0, h0;
    logic [407:0] exp_data;
    w0 = wr_n[2]; h0 = sys_hi[2];
    build_big(8'h00, 8'hA5, 1'b0);
    exp_data = tx[511 -: 408];
    spi_frame(2, 408);
    clks(150);
    total_n++;
    if (n_data !== exp_data) $display("FAIL nocrc_data: got %h want %h", n_data, exp_data);
    else pass_n++;
    total_n++;
    if ({wr_n[2] - w0, sys_hi[2] - h0} !== {32'd1, 32'd0})
      $display("FAIL nocrc_zero_time: got wr=%0d hold=%0d want 1 0",
               wr_n[2] - w0, sys_hi[2] - h0);
    else pass_n++;
    build_big(8'h01, 8'hA5, 1'b0);
    spi_frame(2, 408);
    clks(200);
    total_n++;
    if ({n_cnt, sys_hi[2] - h0} !== {16'd2, 32'd128})
      $display("FAIL nocrc_time_hold: got cnt=%0d hold=%0d want 2 128", n_cnt, sys_hi[2] - h0);
    else pass_n++;
    exp_data = n_data;
    spi_frame(2, 409);
    total_n++;
    if ({n_code, n_cnt} !== {2'd2, 16'd2}) $display("FAIL nocrc_long: got code=%0d cnt=%0d want 2 2", n_code, n_cnt);
    else pass_n++;
    total_n++;
    if (n_data !== tx[511 -: 408]) $display("FAIL nocrc_long_data: got %h want %h", n_data, tx[511 -: 408]);
    else pass_n++;
  endtask

  task automatic test_reset_mid;
    int w0, e0;
    logic [407:0] exp_data;
    build_big(8'h11, 8'hC3, 1'b1);
    exp_data = tx[511 -: 408];
    w0 = wr_n[1]; e0 = err_n[1];
    cs_n[1] = 1'b0;
    clks(4);
    spi_bits(0, 200);
    rst_n = 1'b0;
    clks(3);
    cs_n[1] = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(10);
    total_n++;
    if ({wr_n[1] - w0, err_n[1] - e0, b_cnt, b_code} !== {32'd0, 32'd0, 16'd0, 2'd0})
      $display("FAIL reset_mid_discard: got wr=%0d err=%0d cnt=%0d code=%0d want 0 0 0 0",
               wr_n[1] - w0, err_n[1] - e0, b_cnt, b_code);
    else pass_n++;
    spi_frame(1, 416);
    total_n++;
    if ({wr_n[1] - w0, b_cnt} !== {32'd1, 16'd1})
      $display("FAIL reset_mid_commit: got wr=%0d cnt=%0d want 1 1", wr_n[1] - w0, b_cnt);
    else pass_n++;
    total_n++;
    if (b_data !== exp_data) $display("FAIL reset_mid_data: got %h want %h", b_data, exp_data);
    else pass_n++;
  endtask

  initial begin
    clks(5);
    rst_n = 1'b1;
    clks(5);
    test_reset();
    test_crc_bad();
    test_crc_good();
    test_glitch();
    test_hold_reload();
    test_wrap();
    test_length_errors();
    test_nocrc();
    test_reset_mid();
    total_n++;
    if (both_n[0] + both_n[1] + both_n[2] !== 0)
      $display("FAIL wr_err_overlap: got %0d want 0", both_n[0] + both_n[1] + both_n[2]);
    else pass_n++;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
